// File: rtl/float64_mul_iter.sv
// Multicycle IEEE-754 binary64 multiplier with round-to-nearest-even.
// Mantissa product is a 53-step shift-add; normalise and round happen in a single cycle.
module float64_mul_iter #(
  parameter logic [63:0] DEFAULT_NAN = 64'h7FFF_FFFF_FFFF_FFFF
) (
  input  logic        ap_clk,
  input  logic        ap_rst,
  input  logic        ap_start,
  output logic        ap_done,
  output logic        ap_idle,
  output logic        ap_ready,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic [63:0] ap_return
);
  typedef enum logic [4:0] {
    StIdle   = 5'b00001,
    StUnpack = 5'b00010,
    StMul    = 5'b00100,
    StRound  = 5'b01000,
    StDone   = 5'b10000
  } state_e;

  state_e state_q, state_d;

  logic [63:0]  a_q, b_q;
  logic [52:0]  sig_a_q, sig_b_q;
  logic [105:0] acc_q;
  logic [11:0]  exp_sum_q;
  logic [5:0]   cnt_q;
  logic         sign_q;

  logic [10:0] exp_a, exp_b, exp_a_eff, exp_b_eff;
  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, sign_ab, special;
  logic [63:0] special_res;
  logic [105:0] pp;

  assign exp_a     = a_q[62:52];
  assign exp_b     = b_q[62:52];
  assign exp_a_eff = (exp_a == 11'd0) ? 11'd1 : exp_a;
  assign exp_b_eff = (exp_b == 11'd0) ? 11'd1 : exp_b;
  assign a_nan     = (exp_a == 11'h7FF) && (a_q[51:0] != 52'd0);
  assign b_nan     = (exp_b == 11'h7FF) && (b_q[51:0] != 52'd0);
  assign a_inf     = (exp_a == 11'h7FF) && (a_q[51:0] == 52'd0);
  assign b_inf     = (exp_b == 11'h7FF) && (b_q[51:0] == 52'd0);
  assign a_zero    = (exp_a == 11'd0) && (a_q[51:0] == 52'd0);
  assign b_zero    = (exp_b == 11'd0) && (b_q[51:0] == 52'd0);
  assign sign_ab   = a_q[63] ^ b_q[63];
  assign pp        = {53'd0, sig_b_q} << cnt_q;

  always_comb begin
    special     = 1'b1;
    special_res = '0;
    if (a_nan) begin
      special_res = a_q | 64'h0008_0000_0000_0000;
    end else if (b_nan) begin
      special_res = b_q | 64'h0008_0000_0000_0000;
    end else if ((a_inf && b_zero) || (a_zero && b_inf)) begin
      special_res = DEFAULT_NAN;
    end else if (a_inf || b_inf) begin
      special_res = {sign_ab, 11'h7FF, 52'd0};
    end else if (a_zero || b_zero) begin
      special_res = {sign_ab, 63'd0};
    end else begin
      special = 1'b0;
    end
  end

  // Normalise, denormalise with sticky jamming, then round to nearest even.
  logic [6:0]         lz;
  logic [105:0]       norm;
  logic signed [12:0] e_norm, sh, e_den, e_fin;
  logic [52:0]        m0, m1;
  logic               g0, s0, g1, s1, inc;
  logic [109:0]       wide;
  logic [53:0]        rnd;
  logic [51:0]        frac_fin;
  logic [63:0]        round_res;

  always_comb begin
    lz = '0;
    for (int i = 0; i < 106; i++) begin
      if (acc_q[i]) lz = 7'(105 - i);
    end
    norm   = acc_q << lz;
    e_norm = $signed({1'b0, exp_sum_q}) - 13'sd1022 - $signed({6'd0, lz});
    m0     = norm[105:53];
    g0     = norm[52];
    s0     = |norm[51:0];
    sh     = 13'sd1 - e_norm;
    wide   = '0;
    m1     = m0;
    g1     = g0;
    s1     = s0;
    e_den  = e_norm;
    if (e_norm <= 13'sd0) begin
      e_den = '0;
      if (sh >= 13'sd55) begin
        m1 = '0;
        g1 = 1'b0;
        s1 = 1'b1;
      end else begin
        wide = {m0, g0, s0, 55'd0} >> sh[5:0];
        m1   = wide[109:57];
        g1   = wide[56];
        s1   = |wide[55:0];
      end
    end
    inc = g1 & (s1 | m1[0]);
    rnd = {1'b0, m1} + {53'd0, inc};
    if (rnd[53]) begin
      e_fin    = e_den + 13'sd1;
      frac_fin = rnd[52:1];
    end else if ((e_den == 13'sd0) && rnd[52]) begin
      e_fin    = 13'sd1;
      frac_fin = rnd[51:0];
    end else begin
      e_fin    = e_den;
      frac_fin = rnd[51:0];
    end
    if (e_fin >= 13'sd2047) begin
      round_res = {sign_q, 11'h7FF, 52'd0};
    end else begin
      round_res = {sign_q, e_fin[10:0], frac_fin};
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (ap_start) state_d = StUnpack;
      StUnpack: state_d = special ? StDone : StMul;
      StMul:    if (cnt_q == 6'd52) state_d = StRound;
      StRound:  state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    ap_done  = (state_q == StDone);
    ap_ready = ap_done;
    ap_idle  = (state_q == StIdle) && !ap_start;
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      ap_return <= '0;
      cnt_q     <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (ap_start) begin
            a_q <= a;
            b_q <= b;
          end
        end
        StUnpack: begin
          sign_q    <= sign_ab;
          sig_a_q   <= {exp_a != 11'd0, a_q[51:0]};
          sig_b_q   <= {exp_b != 11'd0, b_q[51:0]};
          exp_sum_q <= {1'b0, exp_a_eff} + {1'b0, exp_b_eff};
          acc_q     <= '0;
          cnt_q     <= '0;
          if (special) ap_return <= special_res;
        end
        StMul: begin
          if (sig_a_q[cnt_q]) acc_q <= acc_q + pp;
          cnt_q <= cnt_q + 6'd1;
        end
        StRound: ap_return <= round_res;
        default: ;
      endcase
    end
  end
endmodule
